// File: rtl/conv_pkg.sv
// Shared types and geometry for the convolution tile sequencer.
// 6x6 pixel tile, 3x3 kernel, 4x4 result block.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int TILE_DIM = 6;
    localparam int K_DIM    = 3;
    localparam int OUT_DIM  = 4;
    localparam int PIX_W    = 8;
    localparam int RES_W    = 16;

endpackage

// File: rtl/conv_tile_sequencer.sv
// Buffers a 6x6 tile and a 3x3 kernel, kicks the conv engine,
// then streams the 4x4 result block out on a valid/ready port.
module conv_tile_sequencer
    import conv_pkg::*;
#(
    parameter int START_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [PIX_W-1:0] s_data,
    input  logic                    s_kernel,
    output logic                    conv_start,
    input  logic                    conv_done,
    output logic signed [PIX_W-1:0] conv_input_tile [0:TILE_DIM-1][0:TILE_DIM-1],
    output logic signed [PIX_W-1:0] conv_kernel [0:K_DIM-1][0:K_DIM-1],
    input  logic signed [RES_W-1:0] conv_c [0:OUT_DIM-1][0:OUT_DIM-1],
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [RES_W-1:0] m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] ST_LAST = SW'(START_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [2:0]    pix_row;
    logic [2:0]    pix_col;
    logic [1:0]    k_row;
    logic [1:0]    k_col;
    logic          kernel_valid;
    logic [SW-1:0] st_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    idx;
    logic signed [RES_W-1:0] result [0:OUT_DIM-1][0:OUT_DIM-1];

    logic pix_full;
    logic pix_last;
    logic k_last;
    logic pix_acc;
    logic k_acc;
    logic go;

    // Pixel row counter reaching TILE_DIM means all 36 pixels are held.
    assign pix_full = (pix_row == 3'(TILE_DIM));
    assign pix_last = (pix_row == 3'(TILE_DIM - 1))
                   && (pix_col == 3'(TILE_DIM - 1));
    assign k_last   = (k_row == 2'(K_DIM - 1))
                   && (k_col == 2'(K_DIM - 1));

    // A full tile only blocks pixels; kernel beats may still refresh.
    assign s_ready = rst_n && (state == LOAD)
                  && (s_kernel || !pix_full);
    assign pix_acc = s_valid && s_ready && !s_kernel;
    assign k_acc   = s_valid && s_ready && s_kernel;

    // Tile complete and kernel usable, either already or on this edge.
    assign go = (pix_full || (pix_acc && pix_last))
             && (kernel_valid || (k_acc && k_last));

    assign m_data = result[idx[3:2]][idx[1:0]];
    assign m_last = m_valid && (idx == 4'd15);

    // Row-major write of accepted beats into the tile and kernel buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < TILE_DIM; r++)
                for (int c = 0; c < TILE_DIM; c++)
                    conv_input_tile[r][c] <= '0;
            for (int r = 0; r < K_DIM; r++)
                for (int c = 0; c < K_DIM; c++)
                    conv_kernel[r][c] <= '0;
        end else begin
            if (pix_acc)
                conv_input_tile[pix_row][pix_col] <= s_data;
            if (k_acc)
                conv_kernel[k_row][k_col] <= s_data;
        end
    end

    // Sequencer: load, strobe engine, wait with timeout, drain results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            pix_row      <= '0;
            pix_col      <= '0;
            k_row        <= '0;
            k_col        <= '0;
            kernel_valid <= 1'b0;
            st_cnt       <= '0;
            to_cnt       <= '0;
            idx          <= '0;
            conv_start   <= 1'b0;
            m_valid      <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            for (int r = 0; r < OUT_DIM; r++)
                for (int c = 0; c < OUT_DIM; c++)
                    result[r][c] <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (pix_acc) begin
                        if (pix_col == 3'(TILE_DIM - 1)) begin
                            pix_col <= '0;
                            pix_row <= pix_row + 3'd1;
                        end else begin
                            pix_col <= pix_col + 3'd1;
                        end
                    end
                    if (k_acc) begin
                        if (k_col == 2'(K_DIM - 1)) begin
                            k_col <= '0;
                            k_row <= k_last ? 2'd0 : k_row + 2'd1;
                        end else begin
                            k_col <= k_col + 2'd1;
                        end
                        if (k_last)
                            kernel_valid <= 1'b1;
                    end
                    if (go) begin
                        state      <= START;
                        st_cnt     <= '0;
                        conv_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (st_cnt == ST_LAST) begin
                        state      <= WAIT;
                        conv_start <= 1'b0;
                        to_cnt     <= '0;
                    end else begin
                        st_cnt <= st_cnt + SW'(1);
                    end
                end
                WAIT: begin
                    if (conv_done) begin
                        for (int r = 0; r < OUT_DIM; r++)
                            for (int c = 0; c < OUT_DIM; c++)
                                result[r][c] <= conv_c[r][c];
                        state   <= DRAIN;
                        idx     <= '0;
                        m_valid <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= LOAD;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        pix_row     <= '0;
                        pix_col     <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (idx == 4'd15) begin
                            state   <= LOAD;
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            idx     <= '0;
                            pix_row <= '0;
                            pix_col <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Randomised bench for conv_tile_sequencer with an in-bench engine
// and a transaction-level model checked every cycle.
module tb_conv_tile_sequencer;
    import conv_pkg::*;

    localparam int SC = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid, s_ready, s_kernel;
    logic signed [7:0] s_data;
    logic conv_start, conv_done;
    logic signed [7:0] tile_w [0:5][0:5];
    logic signed [7:0] kern_w [0:2][0:2];
    logic signed [15:0] conv_c [0:3][0:3];
    logic m_valid, m_ready, m_last, busy, timeout_err;
    logic signed [15:0] m_data;

    conv_tile_sequencer #(.START_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_kernel(s_kernel),
        .conv_start(conv_start), .conv_done(conv_done),
        .conv_input_tile(tile_w), .conv_kernel(kern_w),
        .conv_c(conv_c),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, $signed(a), $signed(e));
        end
    endfunction

    // ---------------- reference model ----------------
    // ph: 0 loading, 1 starting, 2 waiting, 3 draining
    int ph, mpix, mkc, mscnt, mtcnt, midx;
    bit mkv, merr, macc;
    int mtile [36];
    int mkern [9];
    int mexp [16];

    function automatic bit model_ready();
        return rst_n && ph == 0 && (s_kernel || mpix < 36);
    endfunction

    function automatic int conv_ref(int r, int c);
        int s;
        logic signed [15:0] t;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += mtile[(r + i) * 6 + c + j] * mkern[i * 3 + j];
        t = 16'(s);
        return int'(t);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; mpix = 0; mkc = 0; mkv = 0; merr = 0;
            mscnt = 0; mtcnt = 0; midx = 0;
            foreach (mtile[i]) mtile[i] = 0;
            foreach (mkern[i]) mkern[i] = 0;
        end else begin
            macc = s_valid && model_ready();
            case (ph)
                0: begin
                    if (macc && s_kernel) begin
                        mkern[mkc] = int'(s_data);
                        if (mkc == 8) begin mkc = 0; mkv = 1; end
                        else mkc++;
                    end else if (macc) begin
                        mtile[mpix] = int'(s_data);
                        mpix++;
                    end
                    if (mpix == 36 && mkv) begin
                        ph = 1; mscnt = 0;
                        for (int r = 0; r < 4; r++)
                            for (int c = 0; c < 4; c++)
                                mexp[r * 4 + c] = conv_ref(r, c);
                    end
                end
                1: begin
                    mscnt++;
                    if (mscnt == SC) begin ph = 2; mtcnt = 0; end
                end
                2: begin
                    if (conv_done) begin ph = 3; midx = 0; end
                    else if (mtcnt == TO - 1) begin
                        merr = 1; ph = 0; mpix = 0;
                    end else mtcnt++;
                end
                default: begin
                    if (m_ready) begin
                        if (midx == 15) begin ph = 0; mpix = 0; end
                        else midx++;
                    end
                end
            endcase
        end
    end

    // ---------------- engine model ----------------
    int emode = 0;     // 0 done after edelay, 1 never, 2 done on last WAIT cycle
    int edelay = 20;
    int ecnt;
    bit erun, eprev, efire;
    logic signed [15:0] eres [4][4];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_done = 0; erun = 0; eprev = 0; ecnt = 0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) conv_c[r][c] = '0;
        end else begin
            if (conv_start && !eprev) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        int s;
                        s = 0;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                s += int'(tile_w[r + i][c + j]) * int'(kern_w[i][j]);
                        eres[r][c] = 16'(s);
                        conv_c[r][c] = 16'($urandom);
                    end
                conv_done = 0; ecnt = 0; erun = 1;
            end else if (erun) begin
                ecnt++;
                efire = (emode == 0) ? (ecnt >= edelay)
                      : (emode == 2) ? (ph == 2 && mtcnt == TO - 1) : 1'b0;
                if (efire) begin
                    conv_done = 1; erun = 0;
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) conv_c[r][c] = eres[r][c];
                end
            end
            eprev = conv_start;
        end
    end

    // ---------------- m_ready driver ----------------
    int rmode = 0;
    int rpat = 0;
    always @(negedge clk) begin
        case (rmode)
            0: m_ready = 1;
            1: begin m_ready = (rpat % 4 == 0) || (rpat % 4 == 3); rpat++; end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- per-cycle compare ----------------
    logic signed [15:0] got [$];
    int start_hi = 0;
    int last_hs = 0;
    int waitcyc = 0;

    always @(negedge clk) begin
        int bad;
        #2;
        chk("s_ready", s_ready, model_ready());
        chk("busy", busy, ph != 0);
        chk("conv_start", conv_start, ph == 1);
        chk("m_valid", m_valid, ph == 3);
        chk("timeout_err", timeout_err, merr);
        if (ph == 3) begin
            chk("m_data", m_data, mexp[midx]);
            chk("m_last", m_last, midx == 15);
            if (m_ready) got.push_back(m_data);
        end
        bad = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                if (tile_w[r][c] !== 8'(mtile[r * 6 + c])) bad++;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (kern_w[r][c] !== 8'(mkern[r * 3 + c])) bad++;
        chk("buffers", bad, 0);
        if (conv_start) start_hi++;
        if (m_valid && m_ready && m_last) last_hs++;
        if (busy === 1'b1 && !conv_start && !m_valid) waitcyc++;
    end

    // ---------------- stimulus ----------------
    task automatic send(bit k, logic [7:0] d);
        int n;
        n = 0;
        s_valid = 1; s_kernel = k; s_data = d;
        forever begin
            #1;
            if (s_ready) break;
            @(negedge clk);
            n++;
            if (n > 2000) begin
                chk("send_stall", 0, 1);
                break;
            end
        end
        @(negedge clk);
        s_valid = 0;
        s_kernel = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ph != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tile_completes", ph == 0, 1);
    endtask

    function automatic logic [7:0] patv(int m, int i);
        case (m)
            0: return 8'((i / 6) * 6 + (i % 6));
            1: return 8'h80;
            3: return 8'd1;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic feed(int pm, int km, bit with_k, bit k_first);
        logic [7:0] px [36];
        logic [7:0] kv [9];
        int pi, ki;
        bit takek;
        for (int i = 0; i < 36; i++) px[i] = patv(pm, i);
        for (int i = 0; i < 9; i++) kv[i] = patv(km, i);
        pi = 0; ki = 0;
        while (pi < 36 || (with_k && ki < 9)) begin
            if (!with_k || ki >= 9) takek = 0;
            else if (pi >= 36 || k_first) takek = 1;
            else takek = ($urandom_range(0, 3) == 0);
            if (takek) begin send(1, kv[ki]); ki++; end
            else begin send(0, px[pi]); pi++; end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic run_tile(int pm, int km, bit with_k, bit k_first);
        feed(pm, km, with_k, k_first);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        s_valid = 0; s_kernel = 0; s_data = 0; m_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("post_rst_s_ready", s_ready, 1);

        // ramp tile, unit kernel
        got.delete(); start_hi = 0; last_hs = 0;
        run_tile(0, 3, 1, 1);
        chk("t1_words", got.size(), 16);
        chk("t1_first", got.size() > 0 ? got[0] : 16'sd0, 63);
        chk("t1_last", got.size() > 15 ? got[15] : 16'sd0, 252);
        chk("t1_start_cycles", start_hi, 4);
        chk("t1_last_beats", last_hs, 1);

        // same pixels, kernel reused, stalled sink
        rmode = 1; rpat = 0;
        got.delete(); start_hi = 0;
        run_tile(0, 3, 0, 0);
        chk("t2_words", got.size(), 16);
        chk("t2_first", got.size() > 0 ? got[0] : 16'sd0, 63);
        chk("t2_last", got.size() > 15 ? got[15] : 16'sd0, 252);
        chk("t2_start_cycles", start_hi, 4);

        // extreme negative operands
        rmode = 0;
        got.delete();
        run_tile(1, 1, 1, 0);
        bad = 0;
        foreach (got[i]) if (got[i] !== 16'sd16384) bad++;
        chk("t3_words", got.size(), 16);
        chk("t3_values", bad, 0);

        // random tiles
        for (int t = 0; t < 8; t++) begin
            rmode = 2;
            edelay = $urandom_range(0, 40);
            run_tile(2, 2, 1'($urandom_range(0, 1)), 0);
        end
        rmode = 0;
        wait_idle();

        // done on the final WAIT cycle wins over timeout
        emode = 2;
        got.delete();
        run_tile(2, 2, 1, 1);
        chk("t5_words", got.size(), 16);
        chk("t5_no_timeout", timeout_err, 0);

        // engine never finishes
        emode = 1;
        got.delete(); waitcyc = 0;
        run_tile(2, 2, 0, 0);
        #1;
        chk("t6_wait_cycles", waitcyc, 64);
        chk("t6_timeout_err", timeout_err, 1);
        chk("t6_s_ready", s_ready, 1);
        chk("t6_words", got.size(), 0);

        // next tile runs normally, error stays sticky
        emode = 0; edelay = 20;
        got.delete();
        run_tile(2, 2, 0, 0);
        chk("t7_words", got.size(), 16);
        chk("t7_sticky_err", timeout_err, 1);

        // reset in the middle of a drain
        feed(2, 2, 1, 0);
        begin
            int n;
            n = 0;
            while (!(ph == 3 && midx == 7) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("t8_reach_idx7", midx, 7);
        end
        rst_n = 0;
        #1;
        chk("t8_m_valid", m_valid, 0);
        chk("t8_busy", busy, 0);
        chk("t8_timeout_err", timeout_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        got.delete();

        // fresh kernel required: pixels first
        for (int i = 0; i < 36; i++) send(0, patv(0, i));
        s_valid = 1; s_kernel = 0; s_data = 8'sd99;
        repeat (4) begin
            #1;
            chk("t9_pixel_stalled", s_ready, 0);
            chk("t9_no_start", busy, 0);
            @(negedge clk);
        end
        s_valid = 0;
        for (int i = 0; i < 9; i++) send(1, patv(3, i));
        chk("t9_start_next_edge", busy, 1);
        chk("t9_conv_start", conv_start, 1);
        wait_idle();
        chk("t9_words", got.size(), 16);
        chk("t9_first", got.size() > 0 ? got[0] : 16'sd0, 63);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
